// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the I/D-cache main-memory arbiter.
// The memory read latency is fixed by the memory itself; the arbiter simply counts returns.
package mem_arb_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int MEM_LAT     = 4;
    localparam int BLOCK_WORDS = 8;
    localparam int IDX_W       = $clog2(BLOCK_WORDS);
    localparam int CNT_W       = IDX_W + 1;

    // Clears the word and byte offset bits of a byte address.
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL_ISSUE,
        FILL_DRAIN,
        WRITE,
        DONE
    } state_t;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } req_side_t;

endpackage

// File: rtl/mem_arb_fill_ctr.sv
// Issue and return counters for one block fill.
// The last flags mark the count at which the final issue or return happens.
module mem_arb_fill_ctr
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             issue_en,
    input  logic             ret_en,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic             issue_last,
    output logic             ret_last
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (start) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue_en) issue_cnt <= issue_cnt + CNT_W'(1);
            if (ret_en)   ret_cnt   <= ret_cnt + CNT_W'(1);
        end
    end

    assign issue_last = (issue_cnt == LAST);
    assign ret_last   = (ret_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined main memory between I-side fills,
// D-side fills and D-side write-through words; one transaction in flight at a time.
//
//  state      | meaning
//  IDLE       | sample requests, grant and latch address/data
//  FILL_ISSUE | issue one block read per cycle
//  FILL_DRAIN | all reads issued, wait for the remaining returns
//  WRITE      | single write-through cycle
//  DONE       | pulse done to the granted side
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_fill_vld,
    output logic [IDX_W-1:0]  i_fill_idx,
    output logic [DATA_W-1:0] i_fill_data,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_fill_vld,
    output logic [IDX_W-1:0]  d_fill_idx,
    output logic [DATA_W-1:0] d_fill_data,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              busy
);

    state_t            state, state_nxt;
    req_side_t         side, side_nxt;
    req_side_t         last_grant, last_grant_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              d_any, fill_ret, fill_start, issue_en;
    logic              issue_last, ret_last;
    logic [CNT_W-1:0]  issue_cnt, ret_cnt;

    assign d_any    = d_wr | d_req;
    assign fill_ret = mem_valid && (state == FILL_ISSUE || state == FILL_DRAIN);

    mem_arb_fill_ctr u_fill_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (fill_start),
        .issue_en   (issue_en),
        .ret_en     (fill_ret),
        .issue_cnt  (issue_cnt),
        .ret_cnt    (ret_cnt),
        .issue_last (issue_last),
        .ret_last   (ret_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            side       <= SIDE_I;
            last_grant <= SIDE_I;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            side       <= side_nxt;
            last_grant <= last_grant_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        side_nxt       = side;
        last_grant_nxt = last_grant;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        fill_start     = 1'b0;
        issue_en       = 1'b0;
        mem_en         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state)
            IDLE: begin
                if (i_req || d_any) begin
                    // last_grant only moves on a tie, so a lone requester never costs the other its turn
                    if (i_req && d_any) begin
                        side_nxt       = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
                        last_grant_nxt = side_nxt;
                    end else begin
                        side_nxt = d_any ? SIDE_D : SIDE_I;
                    end
                    if (side_nxt == SIDE_D && d_wr) begin
                        addr_nxt  = d_addr & ~ADDR_W'(1);
                        wdata_nxt = d_wdata;
                        state_nxt = WRITE;
                    end else begin
                        addr_nxt   = ((side_nxt == SIDE_D) ? d_addr : i_addr) & BLOCK_MASK;
                        fill_start = 1'b1;
                        state_nxt  = FILL_ISSUE;
                    end
                end
            end
            FILL_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = addr_q + (ADDR_W'(issue_cnt) << 1);
                issue_en = 1'b1;
                if (issue_last) state_nxt = FILL_DRAIN;
            end
            FILL_DRAIN: begin
                if (fill_ret && ret_last) state_nxt = DONE;
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill outputs are gated so an unqualified mem_rdata never leaks onto an idle port.
    assign i_fill_vld  = fill_ret && (side == SIDE_I);
    assign d_fill_vld  = fill_ret && (side == SIDE_D);
    assign i_fill_idx  = i_fill_vld ? ret_cnt[IDX_W-1:0] : '0;
    assign d_fill_idx  = d_fill_vld ? ret_cnt[IDX_W-1:0] : '0;
    assign i_fill_data = i_fill_vld ? mem_rdata : '0;
    assign d_fill_data = d_fill_vld ? mem_rdata : '0;
    assign i_done      = (state == DONE) && (side == SIDE_I);
    assign d_done      = (state == DONE) && (side == SIDE_D);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random request rounds against a
// transaction-level model of arbitration, fill and write timing.
module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int BW  = 8;
    localparam int K_RD = 0, K_WR = 1, K_IF = 2, K_DF = 3, K_ID = 4, K_DD = 5, K_BUSY = 6;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_fill_vld, i_done, d_fill_vld, d_done;
    logic [2:0]  i_fill_idx, d_fill_idx;
    logic [15:0] i_fill_data, d_fill_data;
    logic        mem_en, mem_wr, busy;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [76:0] outs;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_fill_vld(i_fill_vld), .i_fill_idx(i_fill_idx),
        .i_fill_data(i_fill_data), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_fill_vld(d_fill_vld), .d_fill_idx(d_fill_idx), .d_fill_data(d_fill_data), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
    );

    assign outs = {i_fill_vld, i_fill_idx, i_fill_data, i_done, d_fill_vld, d_fill_idx,
                   d_fill_data, d_done, mem_en, mem_wr, mem_addr, mem_wdata, busy};

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h3C5A;
    endfunction

    // Memory: a read seen in cycle c returns in cycle c+LAT; inj forces a stray valid.
    logic        inj = 1'b0;
    logic [LAT-1:0] pv = '0;
    logic [15:0] pd [LAT];
    logic        iss_v;
    logic [15:0] iss_a;
    initial forever begin
        @(negedge clk);
        iss_v = mem_en && !mem_wr;
        iss_a = mem_addr;
        @(posedge clk);
        #1;
        for (int j = LAT - 1; j > 0; j--) begin
            pv[j] = pv[j-1];
            pd[j] = pd[j-1];
        end
        pv[0]     = iss_v;
        pd[0]     = mem_f(iss_a);
        mem_valid = pv[LAT-1] | inj;
        mem_rdata = pv[LAT-1] ? pd[LAT-1] : 16'h0BAD;
    end

    // Observed events keyed by cycle*8+kind.
    logic [31:0] obs_m [int];
    logic [31:0] exp_m [int];
    initial forever begin
        @(negedge clk);
        if (mem_en && !mem_wr) obs_m[cyc*8+K_RD] = {mem_addr, 16'h0};
        if (mem_en && mem_wr)  obs_m[cyc*8+K_WR] = {mem_addr, mem_wdata};
        if (i_fill_vld)        obs_m[cyc*8+K_IF] = {13'd0, i_fill_idx, i_fill_data};
        if (d_fill_vld)        obs_m[cyc*8+K_DF] = {13'd0, d_fill_idx, d_fill_data};
        if (i_done)            obs_m[cyc*8+K_ID] = 32'h0;
        if (d_done)            obs_m[cyc*8+K_DD] = 32'h0;
        if (busy)              obs_m[cyc*8+K_BUSY] = 32'h0;
    end

    int n_assert = 0, n_fail = 0;

    task automatic check(input string tag, input logic [79:0] o, input logic [79:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Round description and model state.
    bit          r_i, r_dw, r_df;
    int          r_ti, r_td, r_drop;
    logic [15:0] r_ia, r_da, r_dwd;
    bit          m_lg = 1'b0;   // 0: I was last tie winner, 1: D
    int          m_end, m_gi, m_gd;

    task automatic set_round(input bit i, input int ti, input logic [15:0] ia,
                             input bit dw, input bit df, input int td,
                             input logic [15:0] da, input logic [15:0] dwd, input int drop);
        r_i = i; r_ti = ti; r_ia = ia; r_dw = dw; r_df = df; r_td = td;
        r_da = da; r_dwd = dwd; r_drop = drop;
    endtask

    task automatic add_exp(input int c, input int k, input logic [31:0] v, input int cutoff);
        if (c <= cutoff) exp_m[c*8+k] = v;
    endtask

    task automatic model(input int start, input int cutoff);
        int free, g, mt, ti, td;
        bit pi, pw, pf, ci, cd, sd;
        logic [15:0] base;
        pi = r_i; pw = r_dw; pf = r_df;
        ti = start + r_ti; td = start + r_td;
        free = start; m_end = start; m_gi = -1; m_gd = -1;
        while (pi || pw || pf) begin
            mt = 1 << 30;
            if (pi && ti < mt) mt = ti;
            if ((pw || pf) && td < mt) mt = td;
            g  = (mt > free) ? mt : free;
            ci = pi && (ti <= g);
            cd = (pw || pf) && (td <= g);
            if (ci && cd) begin
                sd   = (m_lg == 1'b0);
                m_lg = sd;
            end else begin
                sd = cd;
            end
            if (sd && pw) begin
                add_exp(g + 1, K_WR, {r_da & 16'hFFFE, r_dwd}, cutoff);
                add_exp(g + 1, K_BUSY, 32'h0, cutoff);
                add_exp(g + 2, K_BUSY, 32'h0, cutoff);
                add_exp(g + 2, K_DD, 32'h0, cutoff);
                pw = 1'b0; m_gd = g; free = g + 3;
            end else begin
                base = (sd ? r_da : r_ia) & ~16'(2 * BW - 1);
                for (int k = 0; k < BW; k++) begin
                    add_exp(g + 1 + k, K_RD, {base + 16'(2 * k), 16'h0}, cutoff);
                    add_exp(g + 1 + k + LAT, sd ? K_DF : K_IF,
                            {13'd0, 3'(k), mem_f(base + 16'(2 * k))}, cutoff);
                end
                for (int c = g + 1; c <= g + BW + 1 + LAT; c++) add_exp(c, K_BUSY, 32'h0, cutoff);
                add_exp(g + BW + 1 + LAT, sd ? K_DD : K_ID, 32'h0, cutoff);
                free = g + BW + 2 + LAT;
                if (sd) begin pf = 1'b0; m_gd = g; end
                else    begin pi = 1'b0; m_gi = g; end
            end
            m_end = free;
        end
    endtask

    task automatic compare(input string tag);
        logic [31:0] o;
        foreach (exp_m[k]) begin
            o = obs_m.exists(k) ? obs_m[k] : 32'hxxxxxxxx;
            check($sformatf("%s c%0d kind%0d", tag, k / 8, k % 8), {48'h0, o}, {48'h0, exp_m[k]});
        end
        check({tag, " event_count"}, 80'(obs_m.num()), 80'(exp_m.num()));
        obs_m.delete();
        exp_m.delete();
    endtask

    task automatic run_round(input string tag);
        int start, n;
        start = cyc;
        model(start, 1 << 30);
        n = 0;
        forever begin
            if (i_done) i_req = 1'b0;
            if (d_done) begin
                if (d_wr) d_wr = 1'b0;
                else      d_req = 1'b0;
            end
            if (r_i && cyc == start + r_ti) begin
                i_req = 1'b1; i_addr = r_ia;
            end
            if ((r_dw || r_df) && cyc == start + r_td) begin
                d_wr = r_dw; d_req = r_df; d_addr = r_da; d_wdata = r_dwd;
            end
            if (r_drop >= 0 && cyc == start + r_ti + r_drop) i_req = 1'b0;
            if (m_gi >= 0 && cyc > m_gi) i_addr = 16'($urandom);
            if (m_gd >= 0 && cyc > m_gd) begin
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if (cyc > m_end + 1) break;
            n++;
            if (n > 300) begin
                check({tag, " round_timeout"}, 80'(n), 80'(0));
                break;
            end
            @(negedge clk);
        end
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        #2;
        compare(tag);
        check({tag, " busy_idle"}, {79'h0, busy}, 80'h0);
    endtask

    initial begin
        int start;
        #1;
        check("reset_outputs", {3'b0, outs}, 80'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_round(1, 0, 16'h0246, 0, 0, 0, 16'h0, 16'h0, -1);        run_round("i_fill");
        set_round(0, 0, 16'h0, 1, 0, 0, 16'h1235, 16'hBEEF, -1);     run_round("d_write");
        set_round(1, 0, 16'h1100, 0, 1, 0, 16'h2200, 16'h0, -1);     run_round("tie1");
        set_round(1, 0, 16'h3300, 0, 1, 0, 16'h4400, 16'h0, -1);     run_round("tie2");
        set_round(0, 0, 16'h0, 1, 1, 0, 16'h5677, 16'h1234, -1);     run_round("wr_then_fill");
        set_round(1, 0, 16'h6789, 0, 0, 0, 16'h0, 16'h0, 3);         run_round("i_drop");
        set_round(1, 0, 16'hA00E, 0, 1, 2, 16'hB00F, 16'h0, -1);     run_round("back_to_back");

        // Stray valids while idle must not produce fill strobes.
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        @(negedge clk);
        set_round(0, 0, 16'h0, 1, 0, 1, 16'hFFFF, 16'h5A5A, -1);     run_round("stray_then_wr");

        // Reset in the middle of a fill.
        @(negedge clk);
        start = cyc;
        set_round(1, 0, 16'h7A5E, 0, 0, 0, 16'h0, 16'h0, -1);
        model(start, start + 5);
        i_req = 1'b1; i_addr = 16'h7A5E;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0; i_req = 1'b0; m_lg = 1'b0;
        #1;
        check("reset_mid_fill", {3'b0, outs}, 80'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        compare("after_reset");
        set_round(1, 0, 16'h0F3C, 0, 0, 0, 16'h0, 16'h0, -1);        run_round("fresh_fill");
        set_round(1, 0, 16'h1357, 0, 1, 0, 16'h2468, 16'h0, -1);     run_round("tie_after_reset");

        for (int r = 0; r < 30; r++) begin
            set_round($urandom_range(0, 1), $urandom_range(0, 3), 16'($urandom),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                      16'($urandom), 16'($urandom), -1);
            if (!r_i && !r_dw && !r_df) r_i = 1'b1;
            run_round($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
